// File: rtl/instruction_sequencer.sv
// Program sequencer: fetches instruction words from a sync-read memory and
// issues them to the controller, with counted, nestable hardware loops.
module instruction_sequencer #(
    parameter int depth      = 2,
    parameter int W          = 16,
    parameter int insW       = (depth > 2) ? depth : 2,
    parameter int insD       = ((1 << depth) > W) ? (1 << depth) : W,
    parameter int insWidth   = 4 + 2 + 2 * insW + insD,
    parameter int PCW        = 8,
    parameter int LCW        = 8,
    parameter int LOOP_DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                start,
    input  logic [PCW-1:0]      startAddr,
    output logic [PCW-1:0]      progAddr,
    output logic                progRead,
    input  logic [insWidth-1:0] progData,
    output logic [insWidth-1:0] instruction,
    output logic                instrValid,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int SPW   = $clog2(LOOP_DEPTH + 1);
    localparam int SLOTS = 1 << SPW;

    localparam logic [3:0] OP_LS   = 4'b0100;
    localparam logic [3:0] OP_LE   = 4'b0101;
    localparam logic [3:0] OP_NOP  = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b0111;

    localparam logic [insWidth-1:0] IDLE_INS =
        {4'b1111, {(insWidth-4){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN
    } state_e;

    state_e              state_q, state_d;
    logic [PCW-1:0]      pc_q, pc_d;
    logic                fv_q, fv_d;
    logic [SPW-1:0]      sp_q, sp_d;
    logic [insWidth-1:0] ins_q, ins_d;
    logic                iv_q, iv_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [PCW-1:0]      stk_start_q [SLOTS];
    logic [LCW-1:0]      stk_rem_q   [SLOTS];

    logic                push, dec;
    logic [3:0]          opcode;
    logic [LCW-1:0]      loop_n, n_m1;
    logic [SPW-1:0]      top;
    logic                full, empty;
    logic [PCW-1:0]      top_start;
    logic [LCW-1:0]      top_rem;
    logic                is_ls, is_le, is_nop, is_halt;

    assign opcode    = progData[insWidth-1 -: 4];
    assign loop_n    = progData[LCW-1:0];
    // N=0 runs the body once, same as N=1
    assign n_m1      = (loop_n == '0) ? '0 : loop_n - LCW'(1);
    assign top       = sp_q - SPW'(1);
    assign full      = (sp_q == SPW'(LOOP_DEPTH));
    assign empty     = (sp_q == '0);
    assign top_start = stk_start_q[top];
    assign top_rem   = stk_rem_q[top];

    assign is_ls   = (opcode == OP_LS);
    assign is_le   = (opcode == OP_LE);
    assign is_nop  = (opcode == OP_NOP);
    assign is_halt = (opcode == OP_HALT);

    assign progAddr    = pc_q;
    assign progRead    = (state_q != S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign instruction = ins_q;
    assign instrValid  = iv_q;
    assign done        = done_q;
    assign error       = err_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fv_d    = fv_q;
        sp_d    = sp_q;
        ins_d   = IDLE_INS;
        iv_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        push    = 1'b0;
        dec     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = startAddr;
                    sp_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                pc_d    = pc_q + PCW'(1);
                fv_d    = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                pc_d = pc_q + PCW'(1);
                fv_d = 1'b1;
                if (fv_q) begin
                    unique case (1'b1)
                        is_ls: begin
                            if (full) begin
                                err_d   = 1'b1;
                                sp_d    = '0;
                                fv_d    = 1'b0;
                                state_d = S_IDLE;
                            end else begin
                                push = 1'b1;
                                sp_d = sp_q + SPW'(1);
                            end
                        end
                        is_le: begin
                            if (empty) begin
                                err_d   = 1'b1;
                                fv_d    = 1'b0;
                                state_d = S_IDLE;
                            end else if (top_rem != '0) begin
                                // word already fetched for a+1 is dropped
                                dec  = 1'b1;
                                pc_d = top_start;
                                fv_d = 1'b0;
                            end else begin
                                sp_d = sp_q - SPW'(1);
                            end
                        end
                        is_nop: begin
                        end
                        is_halt: begin
                            done_d  = 1'b1;
                            sp_d    = '0;
                            fv_d    = 1'b0;
                            state_d = S_IDLE;
                        end
                        default: begin
                            ins_d = progData;
                            iv_d  = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            fv_q    <= 1'b0;
            sp_q    <= '0;
            ins_q   <= IDLE_INS;
            iv_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fv_q    <= fv_d;
            sp_q    <= sp_d;
            ins_q   <= ins_d;
            iv_q    <= iv_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < SLOTS; i++) begin
                stk_start_q[i] <= '0;
                stk_rem_q[i]   <= '0;
            end
        end else if (push) begin
            stk_start_q[sp_q] <= pc_q;
            stk_rem_q[sp_q]   <= n_m1;
        end else if (dec) begin
            stk_rem_q[top] <= top_rem - LCW'(1);
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: straight line, loops, nesting,
// faults, start handshake, pc wrap and asynchronous reset mid-loop.
module tb_instruction_sequencer;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  startAddr = '0;
    logic [7:0]  progAddr;
    logic        progRead;
    logic [25:0] progData = '0;
    logic [25:0] instruction;
    logic        instrValid;
    logic        busy;
    logic        done;
    logic        error;

    instruction_sequencer dut (
        .CLK(CLK), .RESETn(RESETn), .start(start), .startAddr(startAddr),
        .progAddr(progAddr), .progRead(progRead), .progData(progData),
        .instruction(instruction), .instrValid(instrValid), .busy(busy),
        .done(done), .error(error)
    );

    always #5 CLK = ~CLK;

    logic [25:0] mem [256];
    always @(posedge CLK) if (progRead) progData <= mem[progAddr];

    localparam logic [25:0] IDLE_INS = {4'b1111, 22'd0};

    function automatic logic [25:0] wd(input logic [3:0] op,
                                       input logic [15:0] last);
        return {op, 6'b0, last};
    endfunction

    logic [25:0] W_LC, W_CV, W_PL, W_LK, W_HALT, W_LE, W_NOP;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int st_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    logic [25:0] fq [$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RESETn) begin
            if (instrValid) fq.push_back(instruction);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [7:0] addr);
        @(negedge CLK);
        #2;
        fq.delete();
        done_cnt = 0;
        start = 1'b1;
        startAddr = addr;
        st_cyc = cyc + 1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        do begin
            @(negedge CLK);
            #1;
            n++;
        end while (busy && n < max);
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic loop_run(input string tag, input logic [15:0] n,
                            input int fwd, input int lat);
        mem[8'h20] = wd(4'b0100, n);
        go(8'h20);
        wait_idle({tag, "_idle"}, 1000);
        chk({tag, "_fwd"}, 32'(fq.size()), 32'(fwd));
        chk({tag, "_lat"}, 32'(done_cyc - st_cyc), 32'(lat));
        chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        W_LC   = wd(4'h1, 16'h1111);
        W_CV   = wd(4'h2, 16'h2222);
        W_PL   = wd(4'h3, 16'h3333);
        W_LK   = wd(4'h8, 16'h8888);
        W_HALT = wd(4'b0111, 16'h0);
        W_LE   = wd(4'b0101, 16'h0);
        W_NOP  = wd(4'b0110, 16'h0);
        for (int i = 0; i < 256; i++) mem[i] = W_NOP;
        mem[8'h10] = W_LC; mem[8'h11] = W_CV;
        mem[8'h12] = W_PL; mem[8'h13] = W_HALT;
        mem[8'h21] = W_CV; mem[8'h22] = W_LE; mem[8'h23] = W_HALT;
        mem[8'h40] = wd(4'b0100, 16'd2); mem[8'h41] = wd(4'b0100, 16'd3);
        mem[8'h42] = W_LK; mem[8'h43] = W_LE;
        mem[8'h44] = W_LE; mem[8'h45] = W_HALT;
        for (int i = 0; i < 3; i++) mem[8'h60 + i] = wd(4'b0100, 16'd1);
        mem[8'h63] = W_CV; mem[8'h64] = W_LE; mem[8'h65] = W_LE;
        mem[8'h66] = W_LE; mem[8'h67] = W_HALT;
        mem[8'h70] = W_LE; mem[8'h71] = W_HALT;
        mem[8'hFE] = W_LC; mem[8'hFF] = W_CV;
        mem[8'h00] = W_PL; mem[8'h01] = W_HALT;

        #12;
        chk("rst_ins", 32'(instruction), 32'(IDLE_INS));
        chk("rst_valid", 32'(instrValid), 32'd0);
        chk("rst_read", 32'(progRead), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(progAddr), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;

        go(8'h10);
        chk("sl_addr", 32'(progAddr), 32'h10);
        chk("sl_read", 32'(progRead), 32'd1);
        @(posedge CLK); #1;
        chk("sl_bubble", 32'(instrValid), 32'd0);
        chk("sl_bubble_ins", 32'(instruction), 32'(IDLE_INS));
        @(posedge CLK); #1;
        chk("sl_first_v", 32'(instrValid), 32'd1);
        chk("sl_first", 32'(instruction), 32'(W_LC));
        wait_idle("sl_idle", 50);
        chk("sl_cnt", 32'(fq.size()), 32'd3);
        chk("sl_w1", 32'(fq[1]), 32'(W_CV));
        chk("sl_w2", 32'(fq[2]), 32'(W_PL));
        chk("sl_lat", 32'(done_cyc - st_cyc), 32'd5);
        chk("sl_done", 32'(done_cnt), 32'd1);

        loop_run("l3", 16'd3, 3, 11);
        chk("l3_w", 32'(fq[2]), 32'(W_CV));
        loop_run("l0", 16'd0, 1, 5);
        loop_run("l255", 16'd255, 255, 767);
        mem[8'h20] = wd(4'b0100, 16'd3);

        go(8'h40);
        wait_idle("nest_idle", 200);
        chk("nest_fwd", 32'(fq.size()), 32'd6);
        chk("nest_w", 32'(fq[5]), 32'(W_LK));
        chk("nest_lat", 32'(done_cyc - st_cyc), 32'd24);
        chk("nest_err", 32'(error), 32'd0);

        go(8'h60);
        wait_idle("ovf_idle", 50);
        chk("ovf_err", 32'(error), 32'd1);
        chk("ovf_done", 32'(done_cnt), 32'd0);
        chk("ovf_fwd", 32'(fq.size()), 32'd0);

        go(8'h70);
        wait_idle("unf_idle", 50);
        chk("unf_err", 32'(error), 32'd1);
        chk("unf_done", 32'(done_cnt), 32'd0);

        go(8'h10);
        chk("clr_err", 32'(error), 32'd0);
        @(negedge CLK); #2;
        start = 1'b1;
        startAddr = 8'h70;
        @(posedge CLK); #1;
        start = 1'b0;
        chk("hs_pc", 32'(progAddr), 32'h11);
        wait_idle("hs_idle", 50);
        chk("hs_cnt", 32'(fq.size()), 32'd3);
        chk("hs_w0", 32'(fq[0]), 32'(W_LC));
        chk("hs_w2", 32'(fq[2]), 32'(W_PL));
        chk("hs_done", 32'(done_cnt), 32'd1);
        chk("hs_err", 32'(error), 32'd0);

        go(8'hFE);
        wait_idle("wrap_idle", 50);
        chk("wrap_cnt", 32'(fq.size()), 32'd3);
        chk("wrap_w0", 32'(fq[0]), 32'(W_LC));
        chk("wrap_w1", 32'(fq[1]), 32'(W_CV));
        chk("wrap_w2", 32'(fq[2]), 32'(W_PL));
        chk("wrap_lat", 32'(done_cyc - st_cyc), 32'd5);

        go(8'h20);
        begin
            int n = 0;
            while (fq.size() < 2 && n < 50) begin
                @(negedge CLK); #1;
                n++;
            end
            chk("mr_reach", 32'(fq.size()), 32'd2);
        end
        #1 RESETn = 1'b0;
        #1;
        chk("mr_ins", 32'(instruction), 32'(IDLE_INS));
        chk("mr_valid", 32'(instrValid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_read", 32'(progRead), 32'd0);
        chk("mr_addr", 32'(progAddr), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_err", 32'(error), 32'd0);
        repeat (2) @(posedge CLK);
        chk("mr_nodone", 32'(done_cnt), 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        go(8'h20);
        wait_idle("mr2_idle", 100);
        chk("mr2_fwd", 32'(fq.size()), 32'd3);
        chk("mr2_lat", 32'(done_cyc - st_cyc), 32'd11);
        chk("mr2_done", 32'(done_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Issues the instruction stream to the master controller, one `insWidth`-bit word per cycle, from a synchronous-read program memory. Hardware loops (nestable, counted) let convolution and pooling inner loops be stored once. Sequencer-only opcodes live in the controller's unused opcode space and are never forwarded. A `start` and `done` handshake connects it to the host.

## Interface
- `depth`, 2: log2 of PE array size D; sets `insW = max(2, depth)`.
- `W`, 16: datapath width; sets `insD = max(1<<depth, W)`.
- `insWidth`, `4+2+2*insW+insD`: instruction word width, 26 at defaults. Field order from MSB: opcode[3:0], ins1[1:0], ins2, ins3, insLast.
- `PCW`, 8: program address width.
- `LCW`, 8: loop count width. Must be ≤ `insD`.
- `LOOP_DEPTH`, 2: loop stack entries.

Ports:
- `CLK`  in  1  clock, rising edge.
- `RESETn`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse. Begins execution at `startAddr`.
- `startAddr`  in  PCW  first program address.
- `progAddr`  out  PCW  program memory address.
- `progRead`  out  1  program memory read enable.
- `progData`  in  insWidth  memory word. Valid the cycle after `progAddr`/`progRead` are sampled.
- `instruction`  out  insWidth  registered word to the controller.
- `instrValid`  out  1  high when `instruction` is a forwarded program word.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse on HALT.
- `error`  out  1  sticky loop-stack fault. Cleared by the next accepted `start`.

## Operation
- Sequencer opcodes:
  - LOOP_START `4'b0100`: N = insLast[LCW-1:0] iterations; N=0 is treated as 1.
  - LOOP_END `4'b0101`.
  - SEQ_NOP `4'b0110`.
  - HALT `4'b0111`.
- All other opcodes are forwarded verbatim.
- IDLE_INS = `{4'b1111, zeros}`. This opcode is ignored by the controller.
- `instruction` carries IDLE_INS whenever nothing is forwarded: bubbles, sequencer opcodes, IDLE.
- States:
  - IDLE: `progRead`=0. An accepted `start` loads pc=`startAddr` and moves to PRIME.
  - PRIME: `progRead`=1, `progAddr`=pc. Next edge: pc+1, fetchValid=1, move to RUN.
  - RUN: `progRead`=1 every cycle. On each edge, `progData` is decoded if fetchValid; otherwise it is a bubble.
- Decode in RUN, per valid word at address a (pc = a+1 is being presented):
  - Forward opcode: instruction ← progData, instrValid ← 1, pc ← pc+1.
  - LOOP_START: push {start=a+1, rem=N-1}, pc ← pc+1. On stack full: error ← 1, go IDLE.
  - LOOP_END, rem≠0: rem ← rem-1, pc ← top.start, fetchValid ← 0 for one cycle. The word for a+1 is discarded, giving one bubble.
  - LOOP_END, rem=0: pop, pc ← pc+1. On stack empty: error ← 1, go IDLE.
  - SEQ_NOP: IDLE_INS, pc ← pc+1.
  - HALT: IDLE_INS, `done` pulses on the same edge, stack is cleared, go IDLE.
- Arithmetic:
  - pc increments modulo 2^PCW; wrap is silent.
  - rem is LCW bits and unsigned.
  - Total body executions = max(N,1).
- `start` while `busy` is ignored.
- `start` in the same cycle HALT is decoded is also ignored. The host re-issues it after `done`.
- Error exit: the stack is cleared and `done` is NOT pulsed.

## Timing
- Reset values: `instruction`=IDLE_INS; `instrValid`, `progRead`, `busy`, `done`, `error`=0; `progAddr`=0; stack empty; state IDLE.
- `start` sampled at edge k:
  - `progAddr`=startAddr during cycle k+1.
  - First `instruction` valid after edge k+2.
- Steady state: one forwarded word per cycle.
- Each sequencer opcode costs one IDLE_INS cycle.
- A taken LOOP_END costs two IDLE_INS cycles: its own slot plus the flushed fetch.
- `progAddr` and `progRead` are combinational from state/pc and are registered-stable within a cycle.
- `busy` falls on the edge that decodes HALT or a fault.
- Reset assertion mid-run takes effect immediately and asynchronously: outputs go to reset values, with no `done` and no final instruction.

## Test plan
- Straight line: program [LOAD_CONSTANTS, CONVOLVE, POOL, HALT] at addr 0x10, start at edge 0.
  - `progAddr`=0x10 in cycle 1.
  - Three valid words after edges 2–4.
  - `done` on edge 5; `busy`=0 after.
- Single loop: [LOOP_START N=3, CONVOLVE, LOOP_END, HALT].
  - CONVOLVE forwarded exactly 3 times.
  - IDLE_INS gaps match the bubble rules.
  - N=0 gives 1 iteration.
  - N=255 gives 255 iterations.
- Nested loop: outer N=2, inner N=3 around LOAD_LOCAL_K.
  - 6 forwards.
  - Stack empty at HALT.
- Faults:
  - Three nested LOOP_STARTs with LOOP_DEPTH=2: `error`=1, IDLE, no `done`.
  - Bare LOOP_END: `error`=1.
  - Next `start` clears `error`.
- Handshake: second `start` mid-run is ignored (pc unchanged). PC wrap: program at 0xFE–0x01 executes in order.
- Reset mid-loop: drop `RESETn` during the 2nd iteration.
  - All outputs are reset values in the same cycle.
  - Fresh `start` runs the full 3 iterations.
